// File: rtl/question_block.sv
// rtl/question_block.sv - "?" block controller: head-bump detect, hop animation, spawn timing, sprite draw.
// Optional shimmer frame counter enabled by defining QBLOCK_SHIMMER_EN.
module question_block #(
    parameter logic [9:0] BLOCK_X     = 10'd300,
    parameter logic [9:0] BLOCK_Y     = 10'd300,
    parameter logic [2:0] BLOCK_LEVEL = 3'd0,
    parameter int         BUMP_HEIGHT = 6,
    parameter int         SPAWN_DELAY = 8,
    parameter int         HIT_BAND    = 4
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    input  logic [2:0] level_num,
    input  logic [9:0] mario_x,
    input  logic [9:0] mario_y,
    input  logic [9:0] luigi_x,
    input  logic [9:0] luigi_y,
    input  logic [9:0] mario_Size_Y,
    input  logic [9:0] luigi_Size_Y,
    input  logic [9:0] mario_Y_Vel,
    input  logic [9:0] luigi_Y_Vel,
    input  logic [1:0] mario_health,
    input  logic [1:0] luigi_health,
    output logic       is_question_empty,
    output logic [9:0] start_x,
    output logic [9:0] start_y,
    output logic       mario_bonk,
    output logic       luigi_bonk,
    output logic       is_question,
    output logic       used_sprite,
    output logic [8:0] question_address,
    output logic [1:0] frame_sel
);

    localparam logic [9:0] HIT_HI     = 10'(BLOCK_Y + 10'd10);
    localparam logic [9:0] HIT_LO     = 10'(32'(BLOCK_Y) + 10 - HIT_BAND);
    localparam logic [9:0] BUMP_MAX   = 10'(BUMP_HEIGHT);
    localparam logic [9:0] DELAY_LAST = 10'(SPAWN_DELAY - 1);

    typedef enum logic [2:0] {FULL, BUMP_UP, BUMP_DOWN, SPAWN_WAIT, EMPTY} state_t;

    state_t     state;
    logic [9:0] offset;
    logic [9:0] delay;
    logic       mario_hit, luigi_hit;
    logic       unused_vel;

    assign unused_vel = ^{mario_Y_Vel[8:0], luigi_Y_Vel[8:0]};

    assign start_x = BLOCK_X;
    assign start_y = BLOCK_Y - 10'd19;

    // Head top must sit just under the block while moving up; y < size would wrap, so it is rejected.
    function automatic logic head_hit(input logic [9:0] x, input logic [9:0] y,
                                      input logic [9:0] size, input logic moving_up,
                                      input logic [1:0] health);
        logic [9:0] top;
        logic [9:0] dx;
        top = y - size;
        dx  = (x >= BLOCK_X) ? (x - BLOCK_X) : (BLOCK_X - x);
        return (level_num == BLOCK_LEVEL) && (health != 2'd0) && moving_up &&
               (y >= size) && (top >= HIT_LO) && (top <= HIT_HI) && (dx < 10'd20);
    endfunction

    assign mario_hit = head_hit(mario_x, mario_y, mario_Size_Y, mario_Y_Vel[9], mario_health);
    assign luigi_hit = head_hit(luigi_x, luigi_y, luigi_Size_Y, luigi_Y_Vel[9], luigi_health);

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state             <= FULL;
            offset            <= 10'd0;
            delay             <= 10'd0;
            is_question_empty <= 1'b0;
            mario_bonk        <= 1'b0;
            luigi_bonk        <= 1'b0;
            used_sprite       <= 1'b0;
        end else begin
            mario_bonk <= mario_hit;
            luigi_bonk <= luigi_hit;
            case (state)
                FULL: begin
                    if (mario_hit || luigi_hit) begin
                        state       <= BUMP_UP;
                        used_sprite <= 1'b1;
                    end
                end
                BUMP_UP: begin
                    offset <= offset + 10'd2;
                    if (offset + 10'd2 == BUMP_MAX)
                        state <= BUMP_DOWN;
                end
                BUMP_DOWN: begin
                    offset <= offset - 10'd2;
                    if (offset == 10'd2) begin
                        state <= SPAWN_WAIT;
                        delay <= 10'd0;
                    end
                end
                SPAWN_WAIT: begin
                    if (delay == DELAY_LAST) begin
                        state             <= EMPTY;
                        is_question_empty <= 1'b1;
                    end else begin
                        delay <= delay + 10'd1;
                    end
                end
                EMPTY: is_question_empty <= 1'b1;
                default: state <= FULL;
            endcase
        end
    end

    logic [9:0] px, py;
    logic       in_block;

    // Block rises by offset, so its top edge moves up the screen.
    assign px       = DrawX - BLOCK_X + 10'd10;
    assign py       = DrawY - (BLOCK_Y - offset) + 10'd10;
    assign in_block = (level_num == BLOCK_LEVEL) && (px < 10'd20) && (py < 10'd20);

    assign is_question      = in_block;
    assign question_address = in_block ? (9'(px) + 9'(py) * 9'd20) : 9'd0;

`ifdef QBLOCK_SHIMMER_EN
    logic [5:0] shimmer_cnt;

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset)
            shimmer_cnt <= 6'd0;
        else
            shimmer_cnt <= shimmer_cnt + 6'd1;
    end

    assign frame_sel = (state == FULL) ? shimmer_cnt[5:4] : 2'd0;
`else
    assign frame_sel = 2'd0;
`endif

endmodule

// File: tb/tb_question_block.sv
// tb/tb_question_block.sv - self-checking bench for question_block against a behavioural model.
module tb_question_block;

    logic       frame_clk = 1'b0;
    logic       Reset;
    logic [9:0] DrawX, DrawY;
    logic [2:0] level_num;
    logic [9:0] mario_x, mario_y, luigi_x, luigi_y;
    logic [9:0] mario_Size_Y, luigi_Size_Y, mario_Y_Vel, luigi_Y_Vel;
    logic [1:0] mario_health, luigi_health;
    logic       is_question_empty, mario_bonk, luigi_bonk, is_question, used_sprite;
    logic [9:0] start_x, start_y;
    logic [8:0] question_address;
    logic [1:0] frame_sel;

    int checks   = 0;
    int failures = 0;

    question_block dut (
        .frame_clk(frame_clk), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY),
        .level_num(level_num), .mario_x(mario_x), .mario_y(mario_y),
        .luigi_x(luigi_x), .luigi_y(luigi_y), .mario_Size_Y(mario_Size_Y),
        .luigi_Size_Y(luigi_Size_Y), .mario_Y_Vel(mario_Y_Vel), .luigi_Y_Vel(luigi_Y_Vel),
        .mario_health(mario_health), .luigi_health(luigi_health),
        .is_question_empty(is_question_empty), .start_x(start_x), .start_y(start_y),
        .mario_bonk(mario_bonk), .luigi_bonk(luigi_bonk), .is_question(is_question),
        .used_sprite(used_sprite), .question_address(question_address), .frame_sel(frame_sel)
    );

    always #5 frame_clk = ~frame_clk;

    // Reference: block at (300,300), 20x20, room 0, contact band for head top is 306..310.
    function automatic bit model_hit(int x, int y, int size, int vel, int health, int lvl);
        int top;
        top = y - size;
        return (lvl == 0) && (health != 0) && (vel >= 512) && (top >= 306) && (top <= 310) &&
               (x - 300 < 20) && (300 - x < 20);
    endfunction

    function automatic bit model_draw(int dx, int dy, int o, int lvl);
        return (lvl == 0) && (dx >= 290) && (dx <= 309) && (dy >= 290 - o) && (dy <= 309 - o);
    endfunction

    function automatic int model_hop_offset(int j);
        int table_off [7] = '{0, 2, 4, 6, 4, 2, 0};
        return (j >= 0 && j < 7) ? table_off[j] : 0;
    endfunction

    task automatic park();
        level_num    = 3'd0;
        mario_x      = 10'd50;  mario_y = 10'd100; mario_Size_Y = 10'd16;
        mario_Y_Vel  = 10'd0;   mario_health = 2'd3;
        luigi_x      = 10'd600; luigi_y = 10'd100; luigi_Size_Y = 10'd16;
        luigi_Y_Vel  = 10'd0;   luigi_health = 2'd3;
    endtask

    task automatic mario_at_block();
        mario_x = 10'd300; mario_Size_Y = 10'd16; mario_y = 10'd326; mario_Y_Vel = 10'h3FD;
    endtask

    task automatic do_reset();
        park();
        DrawX = 10'd0; DrawY = 10'd0;
        Reset = 1'b1;
        @(negedge frame_clk);
        @(negedge frame_clk);
        Reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        Reset = 1'b1;
        #1;
        checks++;
        if ({is_question_empty, mario_bonk, luigi_bonk, used_sprite, frame_sel} !== 6'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%b want=000000",
                     {is_question_empty, mario_bonk, luigi_bonk, used_sprite, frame_sel});
        end
        checks++;
        if (start_x !== 10'd300 || start_y !== 10'd281) begin
            failures++;
            $display("FAIL reset_start got=(%0d,%0d) want=(300,281)", start_x, start_y);
        end
        @(negedge frame_clk);
        Reset = 1'b0;
    endtask

    task automatic test_draw();
        int xs [4] = '{290, 309, 310, 300};
        int ys [4] = '{290, 309, 309, 300};
        int ls [4] = '{0, 0, 0, 1};
        int n;
        int dx, dy, lvl, want_addr;
        bit want_q;
        n = 4 + 60;
        for (int i = 0; i < n; i++) begin
            if (i < 4) begin
                dx = xs[i]; dy = ys[i]; lvl = ls[i];
            end else begin
                dx  = int'($urandom_range(275, 325));
                dy  = int'($urandom_range(275, 325));
                lvl = ($urandom_range(0, 5) == 0) ? 1 : 0;
            end
            DrawX = 10'(dx); DrawY = 10'(dy); level_num = 3'(lvl);
            #1;
            want_q    = model_draw(dx, dy, 0, lvl);
            want_addr = want_q ? (dx - 290) + (dy - 290) * 20 : 0;
            checks++;
            if (is_question !== want_q || question_address !== 9'(want_addr)) begin
                failures++;
                $display("FAIL draw(%0d,%0d,lvl%0d) got q=%b addr=%0d want q=%b addr=%0d",
                         dx, dy, lvl, is_question, question_address, want_q, want_addr);
            end
        end
        level_num = 3'd0;
    endtask

    task automatic test_no_hit();
        bit want;
        do_reset();
        for (int p = 0; p < 6; p++) begin
            @(negedge frame_clk);
            park();
            mario_at_block();
            case (p)
                0: mario_Y_Vel  = 10'd2;
                1: mario_x      = 10'd321;
                2: mario_health = 2'd0;
                3: level_num    = 3'd1;
                4: mario_y      = 10'd327;
                default: mario_y = 10'd321;
            endcase
            want = model_hit(int'(mario_x), int'(mario_y), int'(mario_Size_Y),
                             int'(mario_Y_Vel), int'(mario_health), int'(level_num));
            @(posedge frame_clk);
            #1;
            checks++;
            if (mario_bonk !== want || used_sprite !== 1'b0) begin
                failures++;
                $display("FAIL no_hit[%0d] got bonk=%b used=%b want bonk=%b used=0",
                         p, mario_bonk, used_sprite, want);
            end
        end
        @(negedge frame_clk);
        park();
    endtask

    task automatic test_hop(input bit dual, input int rehit_j);
        int  o;
        bit  want_m, want_l;
        @(negedge frame_clk);
        mario_at_block();
        if (dual) begin
            luigi_x = 10'd310; luigi_Size_Y = 10'd20; luigi_y = 10'd330; luigi_Y_Vel = 10'h3F0;
        end
        for (int j = 0; j <= 17; j++) begin
            @(posedge frame_clk);
            #1;
            o      = model_hop_offset(j);
            want_m = (j == 0) || (j == rehit_j + 1);
            want_l = dual && (j == 0);
            checks++;
            if (mario_bonk !== want_m || luigi_bonk !== want_l) begin
                failures++;
                $display("FAIL hop_bonk[j=%0d] got m=%b l=%b want m=%b l=%b",
                         j, mario_bonk, luigi_bonk, want_m, want_l);
            end
            checks++;
            if (is_question_empty !== (j >= 14) || used_sprite !== 1'b1) begin
                failures++;
                $display("FAIL hop_state[j=%0d] got empty=%b used=%b want empty=%b used=1",
                         j, is_question_empty, used_sprite, (j >= 14));
            end
            DrawX = 10'd300; DrawY = 10'(290 - o);
            #1;
            checks++;
            if (is_question !== 1'b1) begin
                failures++;
                $display("FAIL hop_top_row[j=%0d] got q=%b want q=1 (offset %0d)", j, is_question, o);
            end
            DrawY = 10'(289 - o);
            #1;
            checks++;
            if (is_question !== 1'b0) begin
                failures++;
                $display("FAIL hop_above[j=%0d] got q=%b want q=0 (offset %0d)", j, is_question, o);
            end
            @(negedge frame_clk);
            park();
            if (j == rehit_j) mario_at_block();
        end
        checks++;
        if (start_x !== 10'd300 || start_y !== 10'd281) begin
            failures++;
            $display("FAIL hop_start got=(%0d,%0d) want=(300,281)", start_x, start_y);
        end
    endtask

    task automatic test_random_bonk();
        int  top, size, y, x, vel, hl, lvl;
        bit  want_m, want_l;
        for (int i = 0; i < 150; i++) begin
            @(negedge frame_clk);
            lvl = ($urandom_range(0, 7) == 0) ? 1 : 0;
            level_num = 3'(lvl);
            size = int'($urandom_range(4, 30)); top = int'($urandom_range(300, 316));
            y = ($urandom_range(0, 9) == 0) ? size - 1 : top + size;
            x = int'($urandom_range(275, 325)); vel = int'($urandom_range(0, 1023));
            hl = int'($urandom_range(0, 3));
            mario_x = 10'(x); mario_y = 10'(y); mario_Size_Y = 10'(size);
            mario_Y_Vel = 10'(vel); mario_health = 2'(hl);
            want_m = model_hit(x, y, size, vel, hl, lvl);
            size = int'($urandom_range(4, 30)); top = int'($urandom_range(300, 316));
            y = top + size;
            x = int'($urandom_range(275, 325)); vel = int'($urandom_range(0, 1023));
            hl = int'($urandom_range(0, 3));
            luigi_x = 10'(x); luigi_y = 10'(y); luigi_Size_Y = 10'(size);
            luigi_Y_Vel = 10'(vel); luigi_health = 2'(hl);
            want_l = model_hit(x, y, size, vel, hl, lvl);
            @(posedge frame_clk);
            #1;
            checks++;
            if (mario_bonk !== want_m || luigi_bonk !== want_l || is_question_empty !== 1'b1) begin
                failures++;
                $display("FAIL rand_bonk[%0d] got m=%b l=%b empty=%b want m=%b l=%b empty=1",
                         i, mario_bonk, luigi_bonk, is_question_empty, want_m, want_l);
            end
        end
        @(negedge frame_clk);
        park();
    endtask

    task automatic test_reset_mid();
        do_reset();
        @(negedge frame_clk);
        mario_at_block();
        for (int j = 0; j <= 4; j++) begin
            @(posedge frame_clk);
            if (j == 0) begin
                @(negedge frame_clk);
                park();
            end
        end
        #1;
        Reset = 1'b1;
        #1;
        DrawX = 10'd300; DrawY = 10'd290;
        #1;
        checks++;
        if (is_question !== 1'b1 || used_sprite !== 1'b0 || is_question_empty !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid got q=%b used=%b empty=%b want q=1 used=0 empty=0",
                     is_question, used_sprite, is_question_empty);
        end
        DrawY = 10'd289;
        #1;
        checks++;
        if (is_question !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_offset got q=%b want q=0", is_question);
        end
        @(negedge frame_clk);
        Reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_draw();
        test_no_hit();
        do_reset();
        test_hop(1'b0, -10);
        test_random_bonk();
        do_reset();
        test_hop(1'b1, -10);
        do_reset();
        test_hop(1'b0, 9);
        test_reset_mid();
        test_hop(1'b0, -10);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
